start_token_fifo_srl: RTL



---
 rtl/start_token_fifo_pkg.sv | 13 +
 rtl/start_token_fifo_srl_if.sv | 29 ++
 rtl/start_token_fifo_srl_mem.sv | 29 ++
 rtl/start_token_fifo_srl.sv | 73 +++++++
 4 files changed

// File: rtl/start_token_fifo_pkg.sv
// Shared constants and helpers for the start-token SRL FIFO.
package start_token_fifo_pkg;

  // Handshake flag values while in reset: space available, nothing to read.
  localparam logic FULL_N_RST  = 1'b1;
  localparam logic EMPTY_N_RST = 1'b0;

  // Bits needed to hold an occupancy of 0..depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/start_token_fifo_srl_if.sv
// Write/read handshake bundle for the start-token SRL FIFO.
interface start_token_fifo_srl_if #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned ADDR_WIDTH = 1
);

  logic                  if_write_ce;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_full_n;
  logic                  if_read_ce;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_empty_n;
  logic [ADDR_WIDTH:0]   count;

  // Producer/consumer side: drives requests, observes flags and data.
  modport master (
    output if_write_ce, if_write, if_din, if_read_ce, if_read,
    input  if_full_n, if_dout, if_empty_n, count
  );

  // FIFO side.
  modport slave (
    input  if_write_ce, if_write, if_din, if_read_ce, if_read,
    output if_full_n, if_dout, if_empty_n, count
  );

endinterface

// File: rtl/start_token_fifo_srl_mem.sv
// Shift-in register file: a write shifts din into entry 0, reads are addressed.
module start_token_fifo_srl_mem #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned ADDR_WIDTH = 1,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Shift chain; the last entry falls off, but it is never live when we is set.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        mem_q[i] <= mem_q[i-1];
      end
      mem_q[0] <= din;
    end
  end

  // Read port straight from storage.
  assign dout = mem_q[addr];

endmodule

// File: rtl/start_token_fifo_srl.sv
// Start-token FIFO: occupancy counter, registered full_n/empty_n, SRL storage.
module start_token_fifo_srl
  import start_token_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned ADDR_WIDTH = 1,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                   clk,
  input  logic                   ap_rst_n,
  start_token_fifo_srl_if.slave  bus
);

  localparam int unsigned     CntW     = ADDR_WIDTH + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [CntW-1:0]       count_q, count_d, count_m1;
  logic                  full_n_q, empty_n_q;
  logic                  push, pop;
  logic [ADDR_WIDTH-1:0] addr;

  // Handshake decode; gating by the registered flags makes full/empty corners safe.
  always_comb begin
    push = bus.if_write & bus.if_write_ce & full_n_q;
    pop  = bus.if_read  & bus.if_read_ce  & empty_n_q;
  end

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Oldest entry sits at count-1; clamp so an empty FIFO still addresses entry 0.
  always_comb begin
    count_m1 = count_q - CntW'(1);
    addr     = (count_q == '0) ? '0 : count_m1[ADDR_WIDTH-1:0];
  end

  // Counter and flag registers, flags precomputed from the next count.
  always_ff @(posedge clk) begin
    if (!ap_rst_n) begin
      count_q   <= '0;
      full_n_q  <= FULL_N_RST;
      empty_n_q <= EMPTY_N_RST;
    end else begin
      count_q   <= count_d;
      full_n_q  <= (count_d != DepthCnt);
      empty_n_q <= (count_d != '0);
    end
  end

  start_token_fifo_srl_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .addr (addr),
    .din  (bus.if_din),
    .dout (bus.if_dout)
  );

  assign bus.if_full_n  = full_n_q;
  assign bus.if_empty_n = empty_n_q;
  assign bus.count      = count_q;

endmodule
